// File: rtl/pwm_dec_pkg.sv
// Shared definitions for the PWM symbol decoder.
// Holds the FSM state encoding, default parameter values and the
// round-and-saturate helper that turns a pulse width into a symbol.
package pwm_dec_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_SYM_W      = 8;
    localparam int DEF_CNT_W      = 12;
    localparam int DEF_HYST       = 4;
    localparam int DEF_DEB        = 2;
    localparam int DEF_SLOT_SHIFT = 2;
    localparam int DEF_MIN_W      = 4;
    localparam int DEF_MAX_W      = 2000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_OVERRUN = 2'd3
    } state_e;

    // Round width to the nearest symbol unit, then clamp to the largest
    // positive value a signed sym_w-bit symbol can carry.
    function automatic int unsigned sat_round(input int unsigned width,
                                              input int unsigned shift,
                                              input int unsigned sym_w);
        int unsigned rounded;
        int unsigned max_sym;
        rounded = (width + (32'd1 << (shift - 1))) >> shift;
        max_sym = (32'd1 << (sym_w - 1)) - 1;
        return (rounded > max_sym) ? max_sym : rounded;
    endfunction

endpackage

// File: rtl/pwm_level_detect.sv
// Input register, hysteresis slicer and debounce for the PWM decoder.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   enable            - when low the debounce run count is held at zero
//   in_valid          - qualifies data_in / ref_in
//   ref_in, data_in   - signed reference and sample
//   valid_out         - in_valid delayed to line up with level/rise/fall
//   level             - accepted (debounced) level
//   rise, fall        - one-cycle accepted edge events
//   settled           - no disagreeing samples are pending
module pwm_level_detect
    import pwm_dec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HYST   = DEF_HYST,
    parameter int DEB    = DEF_DEB
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] ref_in,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     valid_out,
    output logic                     level,
    output logic                     rise,
    output logic                     fall,
    output logic                     settled
);

    localparam int RUN_W = $clog2(DEB + 1);
    localparam logic signed [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);
    localparam logic [RUN_W-1:0] DEB_RUN = RUN_W'(DEB);

    // Stage 1: registered inputs
    logic                     v1_q;
    logic signed [DATA_W-1:0] ref1_q;
    logic signed [DATA_W-1:0] data1_q;

    // Stage 2: slicer and debounce state
    logic             raw_q, raw_d;
    logic             level_q, level_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             v2_q;

    logic signed [DATA_W:0] data_x;
    logic signed [DATA_W:0] ref_x;
    logic                   hi_raw;
    logic                   lo_raw;
    logic                   raw_now;
    logic [RUN_W-1:0]       run_inc;

    always_comb begin
        // One extra bit so ref +/- HYST cannot overflow.
        data_x  = {data1_q[DATA_W-1], data1_q};
        ref_x   = {ref1_q[DATA_W-1], ref1_q};
        hi_raw  = data_x > (ref_x + HYST_X);
        lo_raw  = data_x < (ref_x - HYST_X);
        raw_now = hi_raw ? 1'b1 : (lo_raw ? 1'b0 : raw_q);
        run_inc = run_q + 1'b1;

        raw_d   = raw_q;
        level_d = level_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (v1_q) begin
            raw_d = raw_now;
        end

        if (!enable) begin
            run_d = '0;
        end else if (v1_q) begin
            if (raw_now != level_q) begin
                if (run_inc == DEB_RUN) begin
                    level_d = raw_now;
                    run_d   = '0;
                    rise_d  = raw_now;
                    fall_d  = !raw_now;
                end else begin
                    run_d = run_inc;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q    <= 1'b0;
            ref1_q  <= '0;
            data1_q <= '0;
            raw_q   <= 1'b0;
            level_q <= 1'b0;
            run_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            v1_q    <= in_valid;
            ref1_q  <= ref_in;
            data1_q <= data_in;
            raw_q   <= raw_d;
            level_q <= level_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            v2_q    <= v1_q;
        end
    end

    assign valid_out = v2_q;
    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign settled   = (run_q == '0);

endmodule

// File: rtl/pwm_symbol_decoder.sv
// PWM symbol decoder: measures accepted high pulses in valid samples and
// emits a rounded, saturated symbol or an error strobe per pulse.
// Ports:
//   clock, reset           - clock and synchronous active-high reset
//   enable_counter         - decoder enable; low forces the FSM to idle
//   in_valid               - qualifies data_in / ref_in
//   ref_in, data_in        - signed slicing reference and sample
//   decoded_symbol         - last decoded symbol, held between strobes
//   sym_valid              - one-cycle strobe for a new symbol
//   sym_err                - one-cycle strobe for a runt or overrun pulse
//   pulse_width            - raw width of the last completed pulse, held
module pwm_symbol_decoder
    import pwm_dec_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SYM_W      = DEF_SYM_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HYST       = DEF_HYST,
    parameter int DEB        = DEF_DEB,
    parameter int SLOT_SHIFT = DEF_SLOT_SHIFT,
    parameter int MIN_W      = DEF_MIN_W,
    parameter int MAX_W      = DEF_MAX_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_counter,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] ref_in,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [SYM_W-1:0]  decoded_symbol,
    output logic                     sym_valid,
    output logic                     sym_err,
    output logic [CNT_W-1:0]         pulse_width
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);

    logic valid_dly;
    logic level;
    logic rise;
    logic fall;
    logic settled;

    pwm_level_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST),
        .DEB    (DEB)
    ) u_level_detect (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable_counter),
        .in_valid  (in_valid),
        .ref_in    (ref_in),
        .data_in   (data_in),
        .valid_out (valid_dly),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .settled   (settled)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    // Stage 3: completed-pulse event, registered before the outputs
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] width_q, width_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        width_d   = width_q;
        count_inc = count_q + 1'b1;

        if (!enable_counter) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                // Arm only on a quiet low sample so a pulse already in
                // progress after reset or enable is never measured.
                ST_IDLE: begin
                    if (valid_dly && !level && settled) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (rise) begin
                        count_d = CNT_W'(1);
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (fall) begin
                        width_d = count_q;
                        state_d = ST_ARMED;
                        if (count_q >= MAX_CNT || count_q < MIN_CNT) begin
                            err_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (valid_dly) begin
                        count_d = count_inc;
                        if (count_inc == MAX_CNT) begin
                            state_d = ST_OVERRUN;
                        end
                    end
                end
                ST_OVERRUN: begin
                    // Counter stays saturated at MAX_W here.
                    if (fall) begin
                        err_d   = 1'b1;
                        width_d = count_q;
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            width_q        <= '0;
            decoded_symbol <= '0;
            sym_valid      <= 1'b0;
            sym_err        <= 1'b0;
            pulse_width    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            err_q     <= err_d;
            width_q   <= width_d;
            sym_valid <= done_q && enable_counter;
            sym_err   <= err_q && enable_counter;
            if ((done_q || err_q) && enable_counter) begin
                pulse_width <= width_q;
            end
            if (done_q && enable_counter) begin
                decoded_symbol <= SYM_W'(sat_round(32'(width_q), SLOT_SHIFT, SYM_W));
            end
        end
    end

endmodule

// File: tb/tb_pwm_symbol_decoder.sv
// Directed bench for pwm_symbol_decoder. Two instances share one input
// stream: "a" (HYST 0, DEB 1, MAX_W 50) and "b" (HYST 4, DEB 2, SYM_W 4).
module tb_pwm_symbol_decoder;

    localparam logic signed [15:0] HI = 16'sd300;
    localparam logic signed [15:0] LO = -16'sd100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               enable_counter;
    logic               in_valid;
    logic signed [15:0] ref_in;
    logic signed [15:0] data_in;

    logic signed [7:0]  sym_a;
    logic               sv_a, se_a;
    logic [11:0]        pw_a;
    logic signed [3:0]  sym_b;
    logic               sv_b, se_b;
    logic [11:0]        pw_b;

    pwm_symbol_decoder #(
        .DATA_W(16), .SYM_W(8), .CNT_W(12), .HYST(0), .DEB(1),
        .SLOT_SHIFT(2), .MIN_W(4), .MAX_W(50)
    ) dut_a (
        .clock          (clock),
        .reset          (reset),
        .enable_counter (enable_counter),
        .in_valid       (in_valid),
        .ref_in         (ref_in),
        .data_in        (data_in),
        .decoded_symbol (sym_a),
        .sym_valid      (sv_a),
        .sym_err        (se_a),
        .pulse_width    (pw_a)
    );

    pwm_symbol_decoder #(
        .DATA_W(16), .SYM_W(4), .CNT_W(12), .HYST(4), .DEB(2),
        .SLOT_SHIFT(2), .MIN_W(4), .MAX_W(2000)
    ) dut_b (
        .clock          (clock),
        .reset          (reset),
        .enable_counter (enable_counter),
        .in_valid       (in_valid),
        .ref_in         (ref_in),
        .data_in        (data_in),
        .decoded_symbol (sym_b),
        .sym_valid      (sv_b),
        .sym_err        (se_b),
        .pulse_width    (pw_b)
    );

    int compared   = 0;
    int mismatched = 0;
    int nv_a = 0, ne_a = 0, nv_b = 0, ne_b = 0;

    always @(negedge clock) begin
        if (sv_a) nv_a++;
        if (se_a) ne_a++;
        if (sv_b) nv_b++;
        if (se_b) ne_b++;
    end

    typedef struct {
        bit dut_b;    // which instance is checked
        int hi_len;   // valid high samples
        bit gaps;     // invalid cycle before every high sample
        int exp_w;    // expected pulse_width, -1 = not checked
        int exp_sym;
        int exp_nv;
        int exp_ne;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [15:0] d);
        @(negedge clock);
        in_valid = v;
        data_in  = d;
    endtask

    task automatic send(input logic signed [15:0] d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) step(1'b0, LO);
            step(1'b1, d);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int bv, be, nv, ne, w, s;
        send(LO, 6, 1'b0);
        bv = v.dut_b ? nv_b : nv_a;
        be = v.dut_b ? ne_b : ne_a;
        send(HI, v.hi_len, v.gaps);
        check({tag, " no err before fall"}, (v.dut_b ? ne_b : ne_a) - be, 0);
        send(LO, 10, 1'b0);
        nv = (v.dut_b ? nv_b : nv_a) - bv;
        ne = (v.dut_b ? ne_b : ne_a) - be;
        w  = v.dut_b ? int'(pw_b) : int'(pw_a);
        s  = v.dut_b ? int'(sym_b) : int'(sym_a);
        check({tag, " sym_valid count"}, nv, v.exp_nv);
        check({tag, " sym_err count"}, ne, v.exp_ne);
        check({tag, " decoded_symbol"}, s, v.exp_sym);
        if (v.exp_w >= 0) check({tag, " pulse_width"}, w, v.exp_w);
    endtask

    initial begin
        int bv, be, bv2, be2, lat;
        vec_t extra;

        //               dut  len gaps  w   sym nv ne
        vecs[0] = '{1'b0,  12, 1'b0, 12,  3, 1, 0};  // clean pulse
        vecs[1] = '{1'b0,   3, 1'b0,  3,  3, 0, 1};  // runt, symbol held
        vecs[2] = '{1'b0,   8, 1'b1,  8,  2, 1, 0};  // invalid gaps
        vecs[3] = '{1'b0,  60, 1'b0, -1,  2, 0, 1};  // overrun (MAX_W 50)
        vecs[4] = '{1'b1,  10, 1'b0, 10,  3, 1, 0};  // debounced pulse
        vecs[5] = '{1'b1, 200, 1'b0, 200, 7, 1, 0};  // saturates at 7
        vecs[6] = '{1'b0,  16, 1'b0, 16,  4, 1, 0};

        reset          = 1'b1;
        enable_counter = 1'b1;
        in_valid       = 1'b0;
        ref_in         = 16'sd100;
        data_in        = '0;
        repeat (3) @(negedge clock);
        check("reset sym_a", int'(sym_a), 0);
        check("reset sv_a", int'(sv_a), 0);
        check("reset se_a", int'(se_a), 0);
        check("reset pw_a", int'(pw_a), 0);
        check("reset sym_b", int'(sym_b), 0);
        check("reset sv_b", int'(sv_b), 0);
        check("reset se_b", int'(se_b), 0);
        check("reset pw_b", int'(pw_b), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Single-sample glitch inside a low run: no edge with DEB 2.
        bv = nv_b; be = ne_b;
        send(LO, 4, 1'b0);
        send(HI, 1, 1'b0);
        send(LO, 10, 1'b0);
        check("glitch sym_valid b", nv_b - bv, 0);
        check("glitch sym_err b", ne_b - be, 0);

        // In-band samples (102) keep the level high: width 12 on b.
        bv = nv_b;
        send(LO, 4, 1'b0);
        send(HI, 5, 1'b0);
        send(16'sd102, 4, 1'b0);
        send(HI, 3, 1'b0);
        send(LO, 10, 1'b0);
        check("hyst sym_valid b", nv_b - bv, 1);
        check("hyst width b", int'(pw_b), 12);
        check("hyst symbol b", int'(sym_b), 3);

        // Latency: strobe is registered 3 edges after the edge capturing
        // the fall sample, i.e. visible at the 4th following negedge.
        send(LO, 6, 1'b0);
        send(HI, 12, 1'b0);
        step(1'b1, LO);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (sv_a && lat == 0) lat = k;
        end
        check("latency a", lat, 4);
        check("latency width a", int'(pw_a), 12);
        send(LO, 4, 1'b0);

        // Enable low: a whole pulse goes by with no strobe, outputs held.
        enable_counter = 1'b0;
        bv = nv_a; be = ne_a; bv2 = nv_b; be2 = ne_b;
        send(LO, 4, 1'b0);
        send(HI, 20, 1'b0);
        send(LO, 8, 1'b0);
        check("disabled sym_valid a", nv_a - bv, 0);
        check("disabled sym_err a", ne_a - be, 0);
        check("disabled sym_valid b", nv_b - bv2, 0);
        check("disabled sym_err b", ne_b - be2, 0);
        check("disabled sym held a", int'(sym_a), 3);
        check("disabled width held a", int'(pw_a), 12);
        enable_counter = 1'b1;
        extra = '{1'b0, 20, 1'b0, 20, 5, 1, 0};
        run_vec(extra, "reenable");

        // Reset mid-pulse, input still high afterwards: pulse discarded.
        send(LO, 6, 1'b0);
        send(HI, 5, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midreset sym_a", int'(sym_a), 0);
        check("midreset pw_a", int'(pw_a), 0);
        check("midreset sym_b", int'(sym_b), 0);
        check("midreset pw_b", int'(pw_b), 0);
        reset = 1'b0;
        bv = nv_a; be = ne_a; bv2 = nv_b; be2 = ne_b;
        send(HI, 8, 1'b0);
        send(LO, 10, 1'b0);
        check("discard sym_valid a", nv_a - bv, 0);
        check("discard sym_err a", ne_a - be, 0);
        check("discard sym_valid b", nv_b - bv2, 0);
        check("discard sym_err b", ne_b - be2, 0);
        extra = '{1'b0, 12, 1'b0, 12, 3, 1, 0};
        run_vec(extra, "after reset a");
        check("after reset width b", int'(pw_b), 12);
        check("after reset symbol b", int'(sym_b), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
